ram_sp_param: RTL and testbench
===============================

RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter ADDR_W, default 15, address width; depth = 2^ADDR_W words.
REQ-003 SHALL provide parameter READ_MODE, default 0, write-port read behaviour: 0 write-first, 1 read-first, 2 no-change.
REQ-004 SHALL provide parameter OUT_REG, default 0; 1 adds one output pipeline register stage.
REQ-005 SHALL provide parameter CLEAR_ON_RESET, default 1; 1 zero-fills the array after reset.
REQ-006 SHALL provide port clk_i, input, 1, system clock; one clock, all logic on its rising edge.
REQ-007 SHALL provide port rst_n_i, input, 1, reset, synchronous and active-low.
REQ-008 SHALL provide port en_i, input, 1, access enable.
REQ-009 SHALL provide port we_i, input, 1, write enable, qualified by en_i.
REQ-010 SHALL provide port addr_i, input, ADDR_W, word address.
REQ-011 SHALL provide port din_i, input, DATA_W, write data.
REQ-012 SHALL provide port dout_o, output, DATA_W, registered read data.
REQ-013 SHALL provide port dvalid_o, output, 1, one-cycle strobe marking new data on dout_o.
REQ-014 SHALL provide port ready_o, output, 1, high when accesses are accepted.

Function
REQ-015 SHALL implement the array as inferred block RAM, DATA_W x 2^ADDR_W, one read/write port.
REQ-016 SHALL run a two-state FSM: CLEAR, READY; reset entry is CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-017 SHALL in CLEAR write 0 to address clr_cnt each cycle, clr_cnt counting 0 to 2^ADDR_W-1, then move to READY on the cycle after the last write.
REQ-018 SHALL hold ready_o low in CLEAR and high in READY; ready_o is registered, from FSM state.
REQ-019 SHALL accept an access only when en_i=1 and ready_o=1; accesses while ready_o=0 are dropped (no write, no dvalid_o).
REQ-020 SHALL on accepted write store din_i at addr_i at that edge.
REQ-021 SHALL on accepted read present mem[addr_i] on dout_o with latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), throughput one access per cycle.
REQ-022 SHALL on accepted write drive dout_o with din_i (READ_MODE=0), prior contents (READ_MODE=1), or leave dout_o unchanged with no dvalid_o (READ_MODE=2), same latency as reads.
REQ-023 SHALL assert dvalid_o for exactly one cycle per access producing output, aligned with dout_o in both OUT_REG settings.
REQ-024 SHALL hold dout_o at its last value when no new data arrives.
REQ-025 SHALL treat back-to-back write then read of the same address as returning the newly written data on the read.
REQ-026 SHALL ignore we_i and din_i when en_i=0; clr_cnt wraps only via the state change, never re-entering CLEAR without reset.
REQ-027 SHALL treat an unsupported READ_MODE (3) as write-first.

Reset
REQ-028 SHALL while rst_n_i=0 at a clock edge set dout_o=0, dvalid_o=0, ready_o=0, clr_cnt=0, flush the OUT_REG pipeline valid, and select the reset-entry state.
REQ-029 SHALL on reset asserted mid-CLEAR restart the clear at address 0 after release; reset mid-READY with CLEAR_ON_RESET=0 leaves array contents intact.
REQ-030 SHALL with CLEAR_ON_RESET=0 raise ready_o on the first edge after rst_n_i is released.

Verification
REQ-031 SHALL cover clear: DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=1, release reset -> ready_o low 16 cycles, then high; reads of all 16 addresses return 0x00.
REQ-032 SHALL cover mode: READ_MODE=0/1/2, write 0xA5 to addr 3 holding 0x5A -> dout_o 0xA5 / 0x5A / unchanged with dvalid_o 0 respectively.
REQ-033 SHALL cover latency: OUT_REG=1, reads of addr 1,2,3 on consecutive cycles holding 0x11,0x22,0x33 -> dout_o 0x11,0x22,0x33 two cycles after each, dvalid_o high three cycles.
REQ-034 SHALL cover gating: write 0xFF to addr 7 while ready_o=0 -> after clear, read addr 7 returns 0x00, no dvalid_o during CLEAR.
REQ-035 SHALL cover mid-clear reset: assert rst_n_i=0 at clr_cnt=9, release -> clr_cnt restarts at 0, ready_o rises 16 cycles after release.
REQ-036 SHALL cover write-read: write 0x3C addr 5 then read addr 5 next cycle -> dout_o 0x3C with dvalid_o.

Source files
------------

// File: rtl/ram_sp_param.sv
// Single-port RAM with parameterisable write-port read behaviour, optional output
// register and an optional zero-fill sweep after reset.
module ram_sp_param #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned READ_MODE      = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dvalid_o,
    output logic              ready_o
);

    localparam int unsigned DEPTH      = 2 ** ADDR_W;
    localparam bit          READ_FIRST = (READ_MODE == 1);
    localparam bit          NO_CHANGE  = (READ_MODE == 2);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t ST_ENTRY = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc;
    logic                clr_we;
    logic                out_new;
    logic [DATA_W-1:0]   rd_q;
    logic                rd_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt == '1) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ENTRY;
            ready_o <= 1'b0;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            ready_o <= (state_d == ST_READY);
            if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    // ready_o is only ever high outside CLEAR, so sweep and user writes never collide.
    assign clr_we  = rst_n_i && (state_q == ST_CLEAR);
    assign acc     = rst_n_i && en_i && ready_o;
    assign out_new = acc && !(we_i && NO_CHANGE);

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (acc && we_i) begin
            mem[addr_i] <= din_i;
        end
    end

    // Read-first takes the pre-write array word; modes 0 and 3 forward din_i.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_q   <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= out_new;
            if (out_new) rd_q <= (we_i && !READ_FIRST) ? din_i : mem[addr_i];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] dout_q;
            logic              dvalid_q;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_vld;
                    if (rd_vld) dout_q <= rd_q;
                end
            end

            assign dout_o   = dout_q;
            assign dvalid_o = dvalid_q;
        end else begin : g_no_out_reg
            assign dout_o   = rd_q;
            assign dvalid_o = rd_vld;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sp_param.sv
// Four RAM variants driven by shared stimulus, each checked every cycle against an
// array-based behavioural model, plus directed checks of the key scenarios.
module tb_ram_sp_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout   [4];
    logic       dvalid [4];
    logic       ready  [4];

    // Per-variant configuration: read mode, output register, clear-on-reset.
    int unsigned rm_c  [4] = '{0, 1, 2, 3};
    int unsigned or_c  [4] = '{0, 1, 0, 1};
    int unsigned cor_c [4] = '{1, 1, 1, 0};

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mm    [4][16];
    int unsigned n_rel [4];
    logic        m_rdy [4];
    logic        m_v   [4];
    logic [7:0]  m_d   [4];
    logic        p_v   [4];
    logic [7:0]  p_d   [4];

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .dout_o(dout[0]), .dvalid_o(dvalid[0]), .ready_o(ready[0]));
    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .dout_o(dout[1]), .dvalid_o(dvalid[1]), .ready_o(ready[1]));
    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .dout_o(dout[2]), .dvalid_o(dvalid[2]), .ready_o(ready[2]));
    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(3), .OUT_REG(1), .CLEAR_ON_RESET(0)) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .dout_o(dout[3]), .dvalid_o(dvalid[3]), .ready_o(ready[3]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural view of one rising edge for every variant.
    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            logic       pv;
            logic [7:0] pd;
            pv = 1'b0;
            pd = '0;
            if (!rst_n) begin
                n_rel[d] = 0;
                m_rdy[d] = 1'b0;
                m_v[d]   = 1'b0;
                m_d[d]   = '0;
                p_v[d]   = 1'b0;
                if (cor_c[d] != 0)
                    for (int a = 0; a < 16; a++) mm[d][a] = '0;
            end else begin
                if (en && m_rdy[d]) begin
                    if (we) begin
                        if (rm_c[d] == 1) begin
                            pv = 1'b1;
                            pd = mm[d][addr];
                        end else if (rm_c[d] != 2) begin
                            pv = 1'b1;
                            pd = din;
                        end
                        mm[d][addr] = din;
                    end else begin
                        pv = 1'b1;
                        pd = mm[d][addr];
                    end
                end
                if (or_c[d] == 0) begin
                    m_v[d] = pv;
                    if (pv) m_d[d] = pd;
                end else begin
                    m_v[d] = p_v[d];
                    if (p_v[d]) m_d[d] = p_d[d];
                    p_v[d] = pv;
                    p_d[d] = pd;
                end
                if (n_rel[d] < 1000) n_rel[d]++;
                m_rdy[d] = (cor_c[d] != 0) ? (n_rel[d] >= 16) : (n_rel[d] >= 1);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < 4; d++) begin
            check_eq($sformatf("u%0d_ready", d), 64'(ready[d]), 64'(m_rdy[d]));
            check_eq($sformatf("u%0d_dvalid", d), 64'(dvalid[d]), 64'(m_v[d]));
            check_eq($sformatf("u%0d_dout", d), 64'(dout[d]), 64'(m_d[d]));
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic [3:0] a, input logic [7:0] dt);
        en   = e;
        we   = w;
        addr = a;
        din  = dt;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 3; i++) step();
        check_eq("rst_dout", 64'(dout[0]), 64'h0);
        check_eq("rst_dvalid", 64'(dvalid[1]), 64'h0);
        check_eq("rst_ready", 64'(ready[3]), 64'h0);

        // Writes attempted during the sweep, with a reset landing mid-clear.
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 4'd7, 8'hFF);
        for (int i = 0; i < 9; i++) step();
        check_eq("midclr_ready", 64'(ready[0]), 64'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq("clr_dvalid", 64'(dvalid[0]), 64'h0);
        end
        check_eq("clr_ready_lo", 64'(ready[0]), 64'h0);
        step();
        check_eq("clr_ready_hi", 64'(ready[0]), 64'h1);

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 8'h00);
            step();
            check_eq("clr_read", 64'(dout[0]), 64'h0);
            check_eq("clr_read_v", 64'(dvalid[0]), 64'h1);
        end

        drive(1'b1, 1'b1, 4'd3, 8'h5A);
        step();
        drive(1'b1, 1'b1, 4'd3, 8'hA5);
        step();
        check_eq("wf_dout", 64'(dout[0]), 64'hA5);
        check_eq("nc_dvalid", 64'(dvalid[2]), 64'h0);
        check_eq("nc_dout", 64'(dout[2]), 64'h0);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        step();
        check_eq("rf_dout", 64'(dout[1]), 64'h5A);
        check_eq("rf_dvalid", 64'(dvalid[1]), 64'h1);

        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 4'(i), 8'(i * 8'h11));
            step();
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        step();
        step();
        drive(1'b1, 1'b0, 4'd1, 8'h00);
        step();
        check_eq("lat_v0", 64'(dvalid[1]), 64'h0);
        drive(1'b1, 1'b0, 4'd2, 8'h00);
        step();
        check_eq("lat_d1", 64'(dout[1]), 64'h11);
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        step();
        check_eq("lat_d2", 64'(dout[1]), 64'h22);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        step();
        check_eq("lat_d3", 64'(dout[1]), 64'h33);
        check_eq("lat_v3", 64'(dvalid[1]), 64'h1);
        step();
        check_eq("lat_vend", 64'(dvalid[1]), 64'h0);
        check_eq("lat_hold", 64'(dout[1]), 64'h33);

        drive(1'b1, 1'b1, 4'd5, 8'h3C);
        step();
        drive(1'b1, 1'b0, 4'd5, 8'h00);
        step();
        check_eq("wr_rd_dout", 64'(dout[0]), 64'h3C);
        check_eq("wr_rd_v", 64'(dvalid[0]), 64'h1);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        step();
        check_eq("wr_rd_dout_or", 64'(dout[1]), 64'h3C);

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
